// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Parametrised pipelined carry-lookahead adder/subtractor. Computes
//   a + bx + c0 (mod 2^WIDTH) where bx = sub ? ~b : b and c0 = sub ? ~cin : cin.
//   The sum is split into STAGES slices of WIDTH/STAGES bits. Stage k adds
//   slice k using the registered carry from stage k-1. Unconsumed operand
//   bits and completed sum bits ride along, so all slices leave aligned.
//   A single global enable (adv) stalls every stage together; bubbles hold.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operand set valid          in_ready   accept this cycle (= adv)
//   a, b       operands (WIDTH)           cin        carry-in / borrow-in
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid               out_ready  consumer accepts result
//   s          result (WIDTH)             cout       carry-out (NOT-borrow in sub)
//   ovf        signed overflow            zero       s == 0
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SL = WIDTH / STAGES;
  localparam int NG = SL / BLOCK;

  logic adv;

  // Slice adder: every carry inside a BLOCK-wide group is expanded as a
  // generate/propagate sum of products from the group carry-in; group
  // carry-ins chain from the previous group's lookahead carry-out.
  // Returns {carry_out, sum}.
  function automatic logic [SL:0] cla_slice(
    input logic [SL-1:0] x,
    input logic [SL-1:0] y,
    input logic          ci
  );
    logic [SL-1:0] g;
    logic [SL-1:0] p;
    logic [SL:0]   c;
    logic          cc;
    logic          pp;
    int unsigned   base;
    int unsigned   idx;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int unsigned grp = 0; grp < NG; grp++) begin
      base = grp * BLOCK;
      for (int unsigned i = 0; i < BLOCK; i++) begin
        idx = base + i;
        cc  = 1'b0;
        for (int unsigned m = base; m <= idx; m++) begin
          pp = 1'b1;
          for (int unsigned n = m + 1; n <= idx; n++) begin
            pp = pp & p[n];
          end
          cc = cc | (g[m] & pp);
        end
        pp = 1'b1;
        for (int unsigned n = base; n <= idx; n++) begin
          pp = pp & p[n];
        end
        cc = cc | (c[base] & pp);
        c[idx+1] = cc;
      end
    end
    return {c[SL], p ^ c[SL-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits still to be consumed from this stage onwards.
    localparam int IW = WIDTH - k * SL;

    logic [IW-1:0]         a_in;
    logic [IW-1:0]         bx_in;
    logic                  c_in;
    logic                  v_in;
    logic [SL-1:0]         r_sum;
    logic                  r_co;
    logic [(k+1)*SL-1:0]   sum_nx;
    logic [(k+1)*SL-1:0]   sum_q;
    logic                  c_q;
    logic                  v_q;

    if (k == 0) begin : src
      always_comb begin
        a_in   = a;
        bx_in  = sub ? ~b : b;
        c_in   = cin ^ sub;
        v_in   = in_valid;
        sum_nx = r_sum;
      end
    end else begin : src
      always_comb begin
        a_in   = stg[k-1].fwd.a_q;
        bx_in  = stg[k-1].fwd.bx_q;
        c_in   = stg[k-1].c_q;
        v_in   = stg[k-1].v_q;
        sum_nx = {r_sum, stg[k-1].sum_q};
      end
    end

    always_comb begin
      {r_co, r_sum} = cla_slice(a_in[SL-1:0], bx_in[SL-1:0], c_in);
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= r_co;
        sum_q <= sum_nx;
      end
    end

    if (k < STAGES - 1) begin : fwd
      logic [IW-SL-1:0] a_q;
      logic [IW-SL-1:0] bx_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (adv) begin
          a_q  <= a_in[IW-1:SL];
          bx_q <= bx_in[IW-1:SL];
        end
      end
    end else begin : fin
      logic ovf_q;
      // carry-into-msb XOR carry-out-of-msb, written in its equivalent form:
      // operand sign bits agree and the result sign differs from them.
      always_ff @(posedge clock) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (a_in[SL-1] == bx_in[SL-1]) && (r_sum[SL-1] != a_in[SL-1]);
        end
      end
    end
  end

  always_comb begin
    out_valid = stg[STAGES-1].v_q;
    adv       = !out_valid || out_ready;
    in_ready  = adv;
    s         = stg[STAGES-1].sum_q;
    cout      = stg[STAGES-1].c_q;
    ovf       = stg[STAGES-1].fin.ovf_q;
    zero      = (s == '0);
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: WIDTH=32, STAGES=2, BLOCK=4 ----------------
  logic        iv_a, ir_a, cin_a, sub_a, ov_a, or_a, co_a, of_a, z_a;
  logic [31:0] a_a, b_a, s_a;

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(2), .BLOCK(4)) dut_a (
    .clock(clock), .reset(reset), .in_valid(iv_a), .in_ready(ir_a),
    .a(a_a), .b(b_a), .cin(cin_a), .sub(sub_a),
    .out_valid(ov_a), .out_ready(or_a),
    .s(s_a), .cout(co_a), .ovf(of_a), .zero(z_a)
  );

  // -------- sweep DUTs: 0:(16,4,4)  1:(8,1,4)  2:(64,4,4) --------
  logic [2:0]  iv_x, cin_x, sub_x, or_x;
  logic [2:0]  ir_x, ov_x, co_x, of_x, z_x;
  logic [63:0] a_x [3];
  logic [63:0] b_x [3];
  logic [63:0] s_x [3];

  logic        ir_b, ov_b, co_b, of_b, z_b;
  logic [15:0] s_b;
  logic        ir_c, ov_c, co_c, of_c, z_c;
  logic [7:0]  s_c;
  logic        ir_d, ov_d, co_d, of_d, z_d;
  logic [63:0] s_d;

  pipelined_cla_addsub #(.WIDTH(16), .STAGES(4), .BLOCK(4)) dut_b (
    .clock(clock), .reset(reset), .in_valid(iv_x[0]), .in_ready(ir_b),
    .a(a_x[0][15:0]), .b(b_x[0][15:0]), .cin(cin_x[0]), .sub(sub_x[0]),
    .out_valid(ov_b), .out_ready(or_x[0]),
    .s(s_b), .cout(co_b), .ovf(of_b), .zero(z_b)
  );

  pipelined_cla_addsub #(.WIDTH(8), .STAGES(1), .BLOCK(4)) dut_c (
    .clock(clock), .reset(reset), .in_valid(iv_x[1]), .in_ready(ir_c),
    .a(a_x[1][7:0]), .b(b_x[1][7:0]), .cin(cin_x[1]), .sub(sub_x[1]),
    .out_valid(ov_c), .out_ready(or_x[1]),
    .s(s_c), .cout(co_c), .ovf(of_c), .zero(z_c)
  );

  pipelined_cla_addsub #(.WIDTH(64), .STAGES(4), .BLOCK(4)) dut_d (
    .clock(clock), .reset(reset), .in_valid(iv_x[2]), .in_ready(ir_d),
    .a(a_x[2]), .b(b_x[2]), .cin(cin_x[2]), .sub(sub_x[2]),
    .out_valid(ov_d), .out_ready(or_x[2]),
    .s(s_d), .cout(co_d), .ovf(of_d), .zero(z_d)
  );

  always_comb begin
    ir_x   = {ir_d, ir_c, ir_b};
    ov_x   = {ov_d, ov_c, ov_b};
    co_x   = {co_d, co_c, co_b};
    of_x   = {of_d, of_c, of_b};
    z_x    = {z_d, z_c, z_b};
    s_x[0] = {48'd0, s_b};
    s_x[1] = {56'd0, s_c};
    s_x[2] = s_d;
  end

  // Arithmetic reference: returns {ovf, cout, s}.
  function automatic logic [65:0] model(input int unsigned w, input logic [63:0] x,
                                        input logic [63:0] y, input logic ci, input logic sb);
    logic [64:0] m, bx, tot, low;
    logic        c0;
    m   = (65'd1 << w) - 65'd1;
    bx  = {1'b0, (sb ? ~y : y)} & m;
    c0  = ci ^ sb;
    tot = ({1'b0, x} & m) + bx + {64'd0, c0};
    low = ({1'b0, x} & (m >> 1)) + (bx & (m >> 1)) + {64'd0, c0};
    return {low[w-1] ^ tot[w], tot[w], tot[63:0] & m[63:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        cout, ovf, zero;
  } vec_t;

  vec_t tv [10];

  task automatic wait_result(input string nm);
    int n;
    n = 0;
    while (!ov_a && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'd1);
  endtask

  task automatic directed();
    for (int i = 0; i < 10; i++) begin
      a_a = tv[i].a; b_a = tv[i].b; cin_a = tv[i].cin; sub_a = tv[i].sub;
      iv_a = 1'b1; or_a = 1'b1;
      @(posedge clock); #1;
      iv_a = 1'b0;
      wait_result($sformatf("v%0d", i));
      chk($sformatf("v%0d_s", i),    64'(s_a),  64'(tv[i].s));
      chk($sformatf("v%0d_cout", i), 64'(co_a), 64'(tv[i].cout));
      chk($sformatf("v%0d_ovf", i),  64'(of_a), 64'(tv[i].ovf));
      chk($sformatf("v%0d_zero", i), 64'(z_a),  64'(tv[i].zero));
    end
    @(posedge clock); #1;
  endtask

  task automatic streaming();
    logic [31:0] sa [8];
    logic [31:0] sbv [8];
    logic [7:0]  sc, ss;
    logic [65:0] exq [$];
    logic [65:0] e;
    logic [31:0] hold_s;
    logic        hold_c, hold_o, hold_z;
    int issued, got;
    bit acc, xfer;
    issued = 0; got = 0;
    hold_s = '0; hold_c = 1'b0; hold_o = 1'b0; hold_z = 1'b0;
    sc = 8'($urandom); ss = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sbv[i] = $urandom;
    end
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      iv_a = (issued < 8);
      if (issued < 8) begin
        a_a = sa[issued]; b_a = sbv[issued]; cin_a = sc[issued]; sub_a = ss[issued];
      end
      or_a = !(cyc >= 3 && cyc <= 5);
      #1;
      chk($sformatf("strm_ready_c%0d", cyc), 64'(ir_a), (cyc >= 3 && cyc <= 5) ? 64'd0 : 64'd1);
      if (cyc == 3) begin
        chk("strm_valid_stall", 64'(ov_a), 64'd1);
        hold_s = s_a; hold_c = co_a; hold_o = of_a; hold_z = z_a;
      end
      if (cyc == 4 || cyc == 5) begin
        chk($sformatf("strm_hold_s_c%0d", cyc), 64'(s_a), 64'(hold_s));
        chk($sformatf("strm_hold_f_c%0d", cyc), 64'({co_a, of_a, z_a}),
            64'({hold_c, hold_o, hold_z}));
      end
      acc  = iv_a && ir_a;
      xfer = ov_a && or_a;
      if (xfer) begin
        if (exq.size() == 0) begin
          chk("strm_spurious", 64'd1, 64'd0);
        end else begin
          e = exq.pop_front();
          chk($sformatf("strm_s%0d", got), 64'(s_a), 64'(e[31:0]));
          chk($sformatf("strm_f%0d", got), 64'({co_a, of_a, z_a}),
              64'({e[64], e[65], e[31:0] == 32'd0}));
        end
        got++;
      end
      if (acc) begin
        exq.push_back(model(32, {32'd0, a_a}, {32'd0, b_a}, cin_a, sub_a));
        issued++;
      end
      @(posedge clock); #1;
    end
    iv_a = 1'b0; or_a = 1'b1;
    chk("strm_count", 64'(got), 64'd8);
    chk("strm_left", 64'(exq.size()), 64'd0);
  endtask

  task automatic reset_midstream();
    a_a = 32'd1; b_a = 32'd2; cin_a = 1'b0; sub_a = 1'b0; iv_a = 1'b1; or_a = 1'b1;
    @(posedge clock); #1;
    a_a = 32'd3; b_a = 32'd4;
    @(posedge clock); #1;
    reset = 1'b1;
    a_a = 32'd100; b_a = 32'd200;
    @(posedge clock); #1;
    reset = 1'b0; iv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_ov%0d", i), 64'(ov_a), 64'd0);
      @(posedge clock); #1;
    end
    a_a = 32'h12345678; b_a = 32'h11111111; cin_a = 1'b0; sub_a = 1'b0; iv_a = 1'b1;
    @(posedge clock); #1;
    iv_a = 1'b0;
    wait_result("rst_new");
    chk("rst_new_s", 64'(s_a), 64'h23456789);
    chk("rst_new_f", 64'({co_a, of_a, z_a}), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic sweep(input int n_ops);
    int unsigned wd [3];
    logic [65:0] fifo [3][8];
    int wp [3], rp [3], iss [3], rcv [3];
    logic [63:0] ps [3];
    bit pstall [3];
    logic [65:0] e;
    logic [63:0] m;
    wd = '{16, 8, 64};
    for (int d = 0; d < 3; d++) begin
      wp[d] = 0; rp[d] = 0; iss[d] = 0; rcv[d] = 0; pstall[d] = 0; ps[d] = '0;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (rcv[0] >= n_ops && rcv[1] >= n_ops && rcv[2] >= n_ops) break;
      for (int d = 0; d < 3; d++) begin
        if (pstall[d]) chk($sformatf("sw%0d_hold", d), s_x[d], ps[d]);
        iv_x[d]  = (iss[d] < n_ops) && ($urandom_range(0, 3) != 0);
        a_x[d]   = {$urandom, $urandom};
        b_x[d]   = {$urandom, $urandom};
        cin_x[d] = 1'($urandom);
        sub_x[d] = 1'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          b_x[d] = a_x[d]; sub_x[d] = 1'b1; cin_x[d] = 1'b0;
        end
        or_x[d]  = ($urandom_range(0, 9) < 7);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        pstall[d] = ov_x[d] && !or_x[d];
        ps[d]     = s_x[d];
        if (ov_x[d] && or_x[d]) begin
          if (rp[d] == wp[d]) begin
            chk($sformatf("sw%0d_spurious", d), 64'd1, 64'd0);
          end else begin
            e = fifo[d][rp[d] % 8];
            rp[d]++;
            chk($sformatf("sw%0d_s", d), s_x[d], e[63:0]);
            chk($sformatf("sw%0d_flags", d), 64'({co_x[d], of_x[d], z_x[d]}),
                64'({e[64], e[65], e[63:0] == 64'd0}));
          end
          rcv[d]++;
        end
        if (iv_x[d] && ir_x[d]) begin
          m = (wd[d] == 64) ? '1 : ((64'd1 << wd[d]) - 64'd1);
          fifo[d][wp[d] % 8] = model(wd[d], a_x[d] & m, b_x[d] & m, cin_x[d], sub_x[d]);
          wp[d]++;
          iss[d]++;
        end
      end
      @(posedge clock); #1;
    end
    iv_x = '0;
    for (int d = 0; d < 3; d++) chk($sformatf("sw%0d_count", d), 64'(rcv[d]), 64'(n_ops));
  endtask

  initial begin
    //            a             b             cin   sub   s             cout  ovf   zero
    tv[0] = '{32'd6,        32'hFFFFFFFE, 1'b0, 1'b0, 32'd4,        1'b1, 1'b0, 1'b0};
    tv[1] = '{32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tv[2] = '{32'd5,        32'd5,        1'b0, 1'b1, 32'd0,        1'b1, 1'b0, 1'b1};
    tv[3] = '{32'h0000FFFF, 32'd1,        1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tv[4] = '{32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 32'd1,        1'b1, 1'b0, 1'b0};
    tv[5] = '{32'd0,        32'd1,        1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tv[6] = '{32'h80000000, 32'd1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tv[7] = '{32'd10,       32'd3,        1'b1, 1'b1, 32'd6,        1'b1, 1'b0, 1'b0};
    tv[8] = '{32'd0,        32'd0,        1'b1, 1'b0, 32'd1,        1'b0, 1'b0, 1'b0};
    tv[9] = '{32'd0,        32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    iv_a = 1'b0; or_a = 1'b1; a_a = '0; b_a = '0; cin_a = 1'b0; sub_a = 1'b0;
    iv_x = '0; or_x = '1; cin_x = '0; sub_x = '0;
    for (int d = 0; d < 3; d++) begin
      a_x[d] = '0; b_x[d] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_out_valid", 64'(ov_a), 64'd0);
    chk("rst_in_ready",  64'(ir_a), 64'd1);
    chk("rst_s",         64'(s_a),  64'd0);
    chk("rst_flags",     64'({co_a, of_a, z_a}), 64'b001);
    chk("rst_sweep_ov",  64'(ov_x), 64'd0);
    chk("rst_sweep_z",   64'(z_x),  64'b111);

    directed();
    streaming();
    reset_midstream();
    sweep(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
